// File: rtl/key_pkg.sv
// Shared key types and helpers for the key event path and the decode stage.
package key_pkg;

  localparam int KEY_W  = 16;
  localparam int CODE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } rpt_state_e;

  typedef struct packed {
    rpt_state_e rpt_state;
    logic       fifo_full;
  } key_dbg_t;

  // Lowest set bit wins; an all-zero vector encodes to 0.
  function automatic logic [CODE_W-1:0] lowest_set(input logic [KEY_W-1:0] v);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = KEY_W - 1; i >= 0; i--) begin
      if (v[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_event_queue_if.sv
// Event pop port of the key event queue.
// Handshake: the queue holds evt_valid/evt_code stable until a rising edge with evt_valid & evt_ready.
interface key_event_queue_if
  import key_pkg::*;
#(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              evt_valid;
  logic              evt_ready;
  logic [CODE_W-1:0] evt_code;
  logic              evt_overflow;
  logic [CNT_W-1:0]  evt_count;

  modport master (
    output evt_valid, evt_code, evt_overflow, evt_count,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_code, evt_overflow, evt_count,
    output evt_ready
  );
endinterface

// File: rtl/key_fifo.sv
// Synchronous first-word-fall-through FIFO with sticky overflow flag.
module key_fifo
  import key_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [CODE_W-1:0] din,
  input  logic              pop,
  output logic [CODE_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [CODE_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [CODE_W-1:0] last_q, last_d;
  logic              push_ok, pop_ok;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  // When empty, show the most recently popped code rather than a stale slot.
  assign dout     = empty ? last_q : mem_q[rd_ptr_q];

  always_comb begin
    pop_ok     = pop && !empty;
    push_ok    = push && (!full || pop_ok);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q || (push && !push_ok);
    last_d     = last_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      last_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_ok && !pop_ok) count_d = count_q + CNT_W'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      last_q     <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      last_q     <= last_d;
    end
  end

endmodule

// File: rtl/key_event_queue.sv
// Turns debounced key levels into press events buffered in a FWFT queue.
// Optional auto-repeat of the last pressed key is enabled with `define KEY_REPEAT_EN.
module key_event_queue
  import key_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [KEY_W-1:0] key_deb,
  key_event_queue_if.master evt_if,
  output key_dbg_t         dbg
);

  if (DEPTH < 2 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cfg
    $error("key_event_queue: invalid DEPTH/HOLD_CYCLES/REPEAT_CYCLES");
  end

  logic [KEY_W-1:0]  prev_q, prev_d;
  logic              settle_q;
  logic [KEY_W-1:0]  rise;
  logic              press;
  logic [CODE_W-1:0] press_code;
  logic              push;
  logic [CODE_W-1:0] push_code;
  logic              fifo_full;
  logic              fifo_empty;

  // The cycle right after reset only loads prev, so keys held through reset stay silent.
  always_comb begin
    prev_d     = key_deb;
    rise       = settle_q ? '0 : (key_deb & ~prev_q);
    press      = |rise;
    press_code = lowest_set(rise);
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      prev_q   <= '0;
      settle_q <= 1'b1;
    end else begin
      prev_q   <= prev_d;
      settle_q <= 1'b0;
    end
  end

`ifdef KEY_REPEAT_EN
  localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] REP_LAST  = 32'(REPEAT_CYCLES - 1);

  rpt_state_e        state_q, state_d;
  logic [CODE_W-1:0] held_q, held_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              rpt_fire;

  always_comb begin
    state_d  = state_q;
    held_d   = held_q;
    cnt_d    = cnt_q;
    rpt_fire = 1'b0;
    if (press) begin
      state_d = HOLD;
      held_d  = press_code;
      cnt_d   = '0;
    end else begin
      case (state_q)
        HOLD, REPEAT: begin
          if (!key_deb[held_q]) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == ((state_q == HOLD) ? HOLD_LAST : REP_LAST)) begin
            rpt_fire = 1'b1;
            state_d  = REPEAT;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        default: ;
      endcase
    end
    push      = press || rpt_fire;
    push_code = press ? press_code : held_q;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= IDLE;
      held_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dbg.rpt_state = state_q;
`else
  always_comb begin
    push      = press;
    push_code = press_code;
  end

  assign dbg.rpt_state = IDLE;
`endif

  key_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (RST),
    .push     (push),
    .din      (push_code),
    .pop      (evt_if.evt_ready),
    .dout     (evt_if.evt_code),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (evt_if.evt_count),
    .overflow (evt_if.evt_overflow)
  );

  assign evt_if.evt_valid = !fifo_empty;
  assign dbg.fifo_full    = fifo_full;

endmodule
